// File: rtl/spi_pkg.sv
// Shared SPI subsystem definitions: frame width, synchronizer limits and
// the transmitter state encoding.
package spi_pkg;

    localparam int SPI_SYNC_MIN = 2;
    localparam int SPI_DATA_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RELOAD
    } spi_tx_state_t;

endpackage

// File: rtl/spi_slave_tx_if.sv
// Local-side byte handshake into the SPI slave transmitter holding buffer.
interface spi_slave_tx_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) ();

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level, producing registered
// single-cycle rise and fall strobes in the clk domain.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES    = SPI_SYNC_MIN,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    // Reset to the idle level so no spurious strobe appears after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: one-entry holding buffer feeding an MSB-first
// shifter, with sclk/cs sampled entirely on the system clock.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            cs,
    spi_slave_tx_if.slave   tx,
    output logic            miso,
    output logic            miso_oe,
    output logic            done,
    output logic            underrun
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_tx_state_t     state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic              load;
    logic              accept;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cs),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    assign accept = tx.tx_valid & ~buf_full_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = RELOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                end
            end
            RELOAD: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_fall) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase

        // A load always sees the buffer as it stood before any same-cycle accept.
        if (load) begin
            shreg_d    = buf_full_q ? buf_q : '0;
            bit_cnt_d  = '0;
            underrun_d = ~buf_full_q;
            buf_full_d = 1'b0;
        end

        if (accept) begin
            buf_d      = tx.tx_data;
            buf_full_d = 1'b1;
        end

        miso_oe_d = (state_d != IDLE);
        miso_d    = (state_d != IDLE) ? shreg_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            bit_cnt_q  <= '0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            bit_cnt_q  <= bit_cnt_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign tx.tx_ready = ~buf_full_q;
    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign done        = done_q;
    assign underrun    = underrun_q;

endmodule
